// File: rtl/cpu_debug_harness.sv
// Debug harness that wraps a soft CPU. It sequences the CPU reset, provides
// run / halt / single-step control with one instruction breakpoint, and owns a
// small data memory with a memory-mapped LED register one word past its end.
//
// Data bus: one transfer per cycle with no handshake. DMEM_READ_WRN=0 is a
// store, committed on the rising edge when the harness is in RUN or STEP.
// Loads are combinational and always complete in the same cycle.
module cpu_debug_harness #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int DMEM_DEPTH = 16,
  parameter int NUM_LEDS   = 4,
  parameter int RST_HOLD   = 8
) (
  input  logic                CLK100MHZ,
  input  logic                RST,
  input  logic                RUN,
  input  logic                STEP,
  input  logic                BKPT_EN,
  input  logic [ADDR_W-1:0]   BKPT_ADDR,
  input  logic [ADDR_W-1:0]   IMEM_ADDR,
  input  logic [ADDR_W-1:0]   DMEM_ADDR,
  input  logic [DATA_W-1:0]   DMEM_WDATA,
  input  logic                DMEM_READ_WRN,
  output logic [DATA_W-1:0]   DMEM_RDATA,
  output logic                CPU_RST_N,
  output logic                CPU_HALT,
  output logic [NUM_LEDS-1:0] LED,
  output logic [1:0]          STATE,
  output logic                BKPT_HIT,
  output logic [15:0]         STORE_CNT
);

  localparam int IDX_W  = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;
  localparam int HOLD_W = $clog2(RST_HOLD + 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DMEM_DEPTH);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);

  typedef enum logic [1:0] {
    S_HOLD   = 2'd0,
    S_RUN    = 2'd1,
    S_HALTED = 2'd2,
    S_STEP   = 2'd3
  } state_t;

  state_t              state;
  state_t              next_state;
  logic [HOLD_W-1:0]   hold_cnt;
  logic                hold_done;
  logic                run_q;
  logic                step_q;
  logic                run_edge;
  logic                step_edge;
  logic                resume_q;
  logic                bkpt_match;

  logic [DATA_W-1:0]   mem [DMEM_DEPTH];
  logic [IDX_W-1:0]    mem_idx;
  logic                in_range;
  logic                led_hit;
  logic                store_ok;

  assign STATE     = state;
  assign hold_done = (hold_cnt == HOLD_LAST);
  assign run_edge  = RUN & ~run_q;
  assign step_edge = STEP & ~step_q;

  assign mem_idx   = DMEM_ADDR[IDX_W-1:0];
  assign in_range  = (DMEM_ADDR < DEPTH_A);
  assign led_hit   = (DMEM_ADDR == DEPTH_A);
  assign store_ok  = ~DMEM_READ_WRN & ((state == S_RUN) | (state == S_STEP)) &
                     (in_range | led_hit);

  // Next-state decode; breakpoint is only looked at in RUN, and not on the
  // first RUN cycle after a resume so the CPU can leave the breakpoint address.
  always_comb begin
    next_state = state;
    bkpt_match = 1'b0;
    case (state)
      S_HOLD: begin
        if (hold_done) next_state = RUN ? S_RUN : S_HALTED;
      end
      S_RUN: begin
        bkpt_match = BKPT_EN & (IMEM_ADDR == BKPT_ADDR) & ~resume_q;
        if (!RUN || bkpt_match) next_state = S_HALTED;
      end
      S_HALTED: begin
        if (run_edge)       next_state = S_RUN;
        else if (step_edge) next_state = S_STEP;
      end
      S_STEP: begin
        next_state = S_HALTED;
      end
      default: next_state = S_HOLD;
    endcase
  end

  // State register, hold counter, edge detectors and registered CPU controls.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      state     <= S_HOLD;
      hold_cnt  <= '0;
      run_q     <= 1'b0;
      step_q    <= 1'b0;
      resume_q  <= 1'b0;
      CPU_RST_N <= 1'b0;
      CPU_HALT  <= 1'b1;
      BKPT_HIT  <= 1'b0;
    end else begin
      state     <= next_state;
      run_q     <= RUN;
      step_q    <= STEP;
      resume_q  <= (state == S_HALTED) && (next_state == S_RUN);
      if (state == S_HOLD && !hold_done) hold_cnt <= hold_cnt + 1'b1;
      // Controls are decoded from next_state so they line up with STATE.
      CPU_RST_N <= (next_state != S_HOLD);
      CPU_HALT  <= ~((next_state == S_RUN) || (next_state == S_STEP));
      if (bkpt_match)
        BKPT_HIT <= 1'b1;
      else if (state == S_HALTED && next_state != S_HALTED)
        BKPT_HIT <= 1'b0;
    end
  end

  // Data memory words; cleared by harness reset.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < DMEM_DEPTH; i++) mem[i] <= '0;
    end else if (store_ok && in_range) begin
      mem[mem_idx] <= DMEM_WDATA;
    end
  end

  // LED register and saturating store counter.
  always_ff @(posedge CLK100MHZ or posedge RST) begin
    if (RST) begin
      LED       <= '0;
      STORE_CNT <= '0;
    end else if (store_ok) begin
      if (led_hit) LED <= DMEM_WDATA[NUM_LEDS-1:0];
      if (STORE_CNT != 16'hFFFF) STORE_CNT <= STORE_CNT + 16'd1;
    end
  end

  // Combinational load path: memory, zero-extended LED, or zero.
  always_comb begin
    DMEM_RDATA = '0;
    if (in_range)     DMEM_RDATA = mem[mem_idx];
    else if (led_hit) DMEM_RDATA = DATA_W'(LED);
  end

endmodule

// File: tb/tb_cpu_debug_harness.sv
// Bench for cpu_debug_harness: directed scenarios with literal expectations,
// then randomized traffic compared every cycle against a behavioural model.
module tb_cpu_debug_harness;

  localparam int DEPTH    = 16;
  localparam int HOLD_CYC = 8;

  logic        clk;
  logic        RST;
  logic        RUN;
  logic        STEP;
  logic        BKPT_EN;
  logic [31:0] BKPT_ADDR;
  logic [31:0] IMEM_ADDR;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic        DMEM_READ_WRN;
  logic [31:0] DMEM_RDATA;
  logic        CPU_RST_N;
  logic        CPU_HALT;
  logic [3:0]  LED;
  logic [1:0]  STATE;
  logic        BKPT_HIT;
  logic [15:0] STORE_CNT;

  int checks = 0;
  int errors = 0;
  bit chk_en = 0;

  cpu_debug_harness dut (
    .CLK100MHZ    (clk),
    .RST          (RST),
    .RUN          (RUN),
    .STEP         (STEP),
    .BKPT_EN      (BKPT_EN),
    .BKPT_ADDR    (BKPT_ADDR),
    .IMEM_ADDR    (IMEM_ADDR),
    .DMEM_ADDR    (DMEM_ADDR),
    .DMEM_WDATA   (DMEM_WDATA),
    .DMEM_READ_WRN(DMEM_READ_WRN),
    .DMEM_RDATA   (DMEM_RDATA),
    .CPU_RST_N    (CPU_RST_N),
    .CPU_HALT     (CPU_HALT),
    .LED          (LED),
    .STATE        (STATE),
    .BKPT_HIT     (BKPT_HIT),
    .STORE_CNT    (STORE_CNT)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // Mode: 0 hold, 1 run, 2 halted, 3 step.
  int          m_mode;
  int          m_age;
  bit          m_run_prev;
  bit          m_step_prev;
  bit          m_just_resumed;
  logic [31:0] m_mem [DEPTH];
  logic [3:0]  m_led;
  int          m_stores;
  bit          m_hit;

  task automatic model_reset();
    m_mode = 0;
    m_age = 0;
    m_run_prev = 0;
    m_step_prev = 0;
    m_just_resumed = 0;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
    m_led = '0;
    m_stores = 0;
    m_hit = 0;
  endtask

  task automatic model_step();
    bit run_rise;
    bit step_rise;
    bit cpu_active;
    int nxt;
    run_rise   = RUN && !m_run_prev;
    step_rise  = STEP && !m_step_prev;
    cpu_active = (m_mode == 1) || (m_mode == 3);
    nxt = m_mode;
    if (!DMEM_READ_WRN && cpu_active && DMEM_ADDR <= DEPTH) begin
      if (DMEM_ADDR < DEPTH) m_mem[DMEM_ADDR] = DMEM_WDATA;
      else m_led = DMEM_WDATA[3:0];
      if (m_stores < 65535) m_stores++;
    end
    case (m_mode)
      0: begin
        m_age++;
        if (m_age == HOLD_CYC) nxt = RUN ? 1 : 2;
      end
      1: begin
        if (BKPT_EN && IMEM_ADDR == BKPT_ADDR && !m_just_resumed) begin
          m_hit = 1;
          nxt = 2;
        end
        if (!RUN) nxt = 2;
      end
      2: begin
        if (run_rise) nxt = 1;
        else if (step_rise) nxt = 3;
        if (nxt != 2) m_hit = 0;
      end
      default: nxt = 2;
    endcase
    m_just_resumed = (m_mode == 2) && (nxt == 1);
    m_run_prev  = RUN;
    m_step_prev = STEP;
    m_mode = nxt;
  endtask

  function automatic logic [31:0] model_rdata();
    if (DMEM_ADDR < DEPTH) return m_mem[DMEM_ADDR];
    if (DMEM_ADDR == DEPTH) return {28'b0, m_led};
    return 32'b0;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (chk_en && !RST) model_step();
  end

  // Compare process: every cycle outside reset, DUT against the model.
  always @(negedge clk) begin
    if (chk_en && !RST) begin
      chk("state",     {30'b0, STATE},      32'(m_mode));
      chk("cpu_rst_n", {31'b0, CPU_RST_N},  {31'b0, (m_mode != 0)});
      chk("cpu_halt",  {31'b0, CPU_HALT},   {31'b0, !(m_mode == 1 || m_mode == 3)});
      chk("led",       {28'b0, LED},        {28'b0, m_led});
      chk("bkpt_hit",  {31'b0, BKPT_HIT},   {31'b0, m_hit});
      chk("store_cnt", {16'b0, STORE_CNT},  32'(m_stores));
      chk("rdata",     DMEM_RDATA,          model_rdata());
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic at_neg();
    @(negedge clk);
  endtask

  // Asserts reset between edges, checks outputs settle at once, then
  // releases on a falling edge.
  task automatic do_reset();
    RST = 1'b1;
    DMEM_ADDR = DEPTH;
    #1;
    chk("rst_state",     {30'b0, STATE},     32'd0);
    chk("rst_cpu_rst_n", {31'b0, CPU_RST_N}, 32'd0);
    chk("rst_cpu_halt",  {31'b0, CPU_HALT},  32'd1);
    chk("rst_led",       {28'b0, LED},       32'd0);
    chk("rst_bkpt_hit",  {31'b0, BKPT_HIT},  32'd0);
    chk("rst_store_cnt", {16'b0, STORE_CNT}, 32'd0);
    chk("rst_rdata_led", DMEM_RDATA,         32'd0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    RST = 1'b0;
  endtask

  initial begin
    int n;
    RST = 1'b1;
    RUN = 1'b1;
    STEP = 1'b0;
    BKPT_EN = 1'b0;
    BKPT_ADDR = '0;
    IMEM_ADDR = '0;
    DMEM_ADDR = '0;
    DMEM_WDATA = '0;
    DMEM_READ_WRN = 1'b1;
    do_reset();
    chk_en = 1;

    // CPU reset held for exactly RST_HOLD edges after release.
    n = 0;
    while (n < 20) begin
      at_neg();
      n++;
      if (CPU_RST_N) break;
    end
    chk("hold_cycles", 32'(n), 32'd8);
    chk("hold_state", {30'b0, STATE}, 32'd1);
    chk("hold_halt", {31'b0, CPU_HALT}, 32'd0);

    // LED store then load.
    tick();
    DMEM_ADDR = DEPTH; DMEM_WDATA = 32'h5; DMEM_READ_WRN = 1'b0;
    tick();
    DMEM_READ_WRN = 1'b1;
    at_neg();
    chk("led_store", {28'b0, LED}, 32'h5);
    chk("led_cnt", {16'b0, STORE_CNT}, 32'd1);
    chk("led_load", DMEM_RDATA, 32'h5);

    // Breakpoint at address 2.
    tick();
    BKPT_EN = 1'b1; BKPT_ADDR = 32'd2; IMEM_ADDR = 32'd1;
    tick();
    IMEM_ADDR = 32'd2;
    at_neg();
    chk("pre_bkpt_state", {30'b0, STATE}, 32'd1);
    tick();
    at_neg();
    chk("bkpt_state", {30'b0, STATE}, 32'd2);
    chk("bkpt_halt", {31'b0, CPU_HALT}, 32'd1);
    chk("bkpt_hit", {31'b0, BKPT_HIT}, 32'd1);
    tick();
    RUN = 1'b0;
    tick();
    RUN = 1'b1;
    tick();
    at_neg();
    chk("resume_state", {30'b0, STATE}, 32'd1);
    chk("resume_hit", {31'b0, BKPT_HIT}, 32'd0);
    tick();
    IMEM_ADDR = 32'd5;
    at_neg();
    chk("no_rehalt", {30'b0, STATE}, 32'd1);

    // Single step with a store inside the step cycle.
    tick();
    RUN = 1'b0;
    tick();
    STEP = 1'b1; DMEM_ADDR = 32'd3; DMEM_WDATA = 32'hABCD; DMEM_READ_WRN = 1'b0;
    tick();
    at_neg();
    chk("step_state", {30'b0, STATE}, 32'd3);
    chk("step_halt", {31'b0, CPU_HALT}, 32'd0);
    chk("step_cnt_before", {16'b0, STORE_CNT}, 32'd1);
    tick();
    STEP = 1'b0; DMEM_READ_WRN = 1'b1;
    at_neg();
    chk("after_step_state", {30'b0, STATE}, 32'd2);
    chk("after_step_halt", {31'b0, CPU_HALT}, 32'd1);
    chk("step_store_cnt", {16'b0, STORE_CNT}, 32'd2);
    chk("step_store_data", DMEM_RDATA, 32'hABCD);

    // RUN and STEP edges together: RUN wins.
    tick();
    RUN = 1'b1; STEP = 1'b1;
    tick();
    STEP = 1'b0;
    at_neg();
    chk("run_wins", {30'b0, STATE}, 32'd1);

    // Store beyond the LED address is dropped.
    tick();
    DMEM_ADDR = DEPTH + 3; DMEM_WDATA = 32'hFF; DMEM_READ_WRN = 1'b0;
    tick();
    DMEM_READ_WRN = 1'b1;
    at_neg();
    chk("oob_led", {28'b0, LED}, 32'h5);
    chk("oob_cnt", {16'b0, STORE_CNT}, 32'd2);
    chk("oob_load", DMEM_RDATA, 32'd0);
    tick();
    DMEM_ADDR = 32'd3;
    at_neg();
    chk("oob_mem", DMEM_RDATA, 32'hABCD);

    // Reset in the middle of RUN.
    tick();
    do_reset();

    // Randomized traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 7) == 0) RUN = ~RUN;
        STEP          = ($urandom_range(0, 2) == 0);
        BKPT_EN       = $urandom_range(0, 1);
        BKPT_ADDR     = $urandom_range(0, 3);
        IMEM_ADDR     = $urandom_range(0, 3);
        DMEM_ADDR     = $urandom_range(0, DEPTH + 3);
        DMEM_WDATA    = $urandom;
        DMEM_READ_WRN = $urandom_range(0, 1);
      end
    end
    at_neg();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
